resv_normalize: RTL and testbench

RESV_NORMALIZE -- requirements
Module: resv_normalize

---
 rtl/resv_pkg.sv | 18 +
 rtl/resv_digit_add.sv | 28 ++
 rtl/resv_normalize.sv | 131 +++++++++++++
 tb/tb_resv_normalize.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resv_pkg.sv
// Shared parameters and FSM encoding for the carry-save to binary digit normalizer.
package resv_pkg;

    localparam int RESV_NUM_DIGITS = 130;
    localparam int RESV_RES_W      = 19;
    localparam int RESV_DIGIT_W    = 16;
    localparam int RESV_SUM_W      = RESV_RES_W + 2;
    // Worst case (2*(2^19-1) + 31) >> 16 = 16, so five carry bits never truncate.
    localparam int RESV_CARRY_W    = 5;
    localparam int RESV_IDX_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/resv_digit_add.sv
// One normalization step: adds a carry and sum digit plus the incoming carry,
// then splits the result into an output digit and the outgoing carry.
module resv_digit_add
    import resv_pkg::*;
#(
    parameter int RES_W   = RESV_RES_W,
    parameter int DIGIT_W = RESV_DIGIT_W,
    parameter int CARRY_W = RESV_CARRY_W
) (
    input  logic [RES_W-1:0]   c,
    input  logic [RES_W-1:0]   s,
    input  logic [CARRY_W-1:0] carry_in,
    output logic [DIGIT_W-1:0] digit,
    output logic [CARRY_W-1:0] carry
);

    localparam int SUM_W = RES_W + 2;

    logic [SUM_W-1:0] sum_s;

    // Full-width add so the outgoing carry keeps every bit above the digit.
    always_comb begin
        sum_s = {2'b00, c} + {2'b00, s} + {{(SUM_W - CARRY_W){1'b0}}, carry_in};
        digit = sum_s[DIGIT_W-1:0];
        carry = sum_s[DIGIT_W +: CARRY_W];
    end

endmodule

// File: rtl/resv_normalize.sv
// Serializes a captured carry-save vector into normalized binary digits,
// least significant first, with valid/ready flow control on the output.
module resv_normalize
    import resv_pkg::*;
#(
    parameter int NUM_DIGITS = RESV_NUM_DIGITS,
    parameter int RES_W      = RESV_RES_W,
    parameter int DIGIT_W    = RESV_DIGIT_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_DIGITS-1:0][RES_W-1:0]  C,
    input  logic [NUM_DIGITS-1:0][RES_W-1:0]  S,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DIGIT_W-1:0]                out_digit,
    output logic [RESV_IDX_W-1:0]             out_index,
    output logic                              out_last,
    output logic [RESV_CARRY_W-1:0]           carry_out
);

    localparam logic [RESV_IDX_W-1:0] LAST_IDX = RESV_IDX_W'(NUM_DIGITS - 1);

    state_t                          state_r;
    logic [NUM_DIGITS-1:0][RES_W-1:0] c_r;
    logic [NUM_DIGITS-1:0][RES_W-1:0] s_r;
    // idx_r is the next digit to compute; carry_r is the carry into that digit.
    logic [RESV_IDX_W-1:0]           idx_r;
    logic [RESV_CARRY_W-1:0]         carry_r;

    logic [DIGIT_W-1:0]              add_digit_s;
    logic [RESV_CARRY_W-1:0]         add_carry_s;
    logic                            accept_s;
    logic                            load_s;
    logic                            idx_last_s;

    resv_digit_add #(
        .RES_W   (RES_W),
        .DIGIT_W (DIGIT_W),
        .CARRY_W (RESV_CARRY_W)
    ) u_digit_add (
        .c        (c_r[idx_r]),
        .s        (s_r[idx_r]),
        .carry_in (carry_r),
        .digit    (add_digit_s),
        .carry    (add_carry_s)
    );

    // Decide whether the output register takes a freshly computed digit this cycle.
    always_comb begin
        accept_s   = out_valid && out_ready;
        idx_last_s = (idx_r == LAST_IDX);
        load_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (!out_valid) begin
                    load_s = 1'b1;
                end else begin
                    load_s = accept_s && !out_last;
                end
            end
            HOLD: begin
                load_s = accept_s && !out_last;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // FSM, operand capture, carry chain and registered digit outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            c_r       <= '0;
            s_r       <= '0;
            idx_r     <= '0;
            carry_r   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_digit <= '0;
            out_index <= '0;
            carry_out <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        c_r      <= C;
                        s_r      <= S;
                        idx_r    <= '0;
                        carry_r  <= '0;
                        in_ready <= 1'b0;
                        state_r  <= RUN;
                    end
                end
                RUN, HOLD: begin
                    if (load_s) begin
                        out_digit <= add_digit_s;
                        out_index <= idx_r;
                        out_last  <= idx_last_s;
                        carry_out <= idx_last_s ? add_carry_s : {RESV_CARRY_W{1'b0}};
                        out_valid <= 1'b1;
                        carry_r   <= add_carry_s;
                        if (!idx_last_s) begin
                            idx_r <= idx_r + {{(RESV_IDX_W-1){1'b0}}, 1'b1};
                        end
                        state_r   <= RUN;
                    end else if (accept_s) begin
                        // Last digit taken: release the output and reopen the input.
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        carry_out <= '0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else if (out_valid) begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resv_normalize.sv
// Directed bench for resv_normalize; digit streams are checked against a
// 2096-bit integer sum of all weighted C and S digits.
module tb_resv_normalize;

    localparam int ND = 130;
    localparam int RW = 19;
    localparam int TW = ND * 16 + 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [ND-1:0][RW-1:0]   c_in;
    logic [ND-1:0][RW-1:0]   s_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [15:0]             out_digit;
    logic [7:0]              out_index;
    logic                    out_last;
    logic [4:0]              carry_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] got_digit [ND];
    logic [7:0]  got_index [ND];
    logic        got_last  [ND];
    int          got_cyc   [ND];
    logic [15:0] ref_digit [ND];
    int          n_got;
    bit          timeout;
    int          hold_err;
    logic [4:0]  got_carry;
    logic [TW-1:0] exp_total;

    resv_normalize dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (c_in),
        .S         (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_index (out_index),
        .out_last  (out_last),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [TW-1:0] golden(input logic [ND-1:0][RW-1:0] c, input logic [ND-1:0][RW-1:0] s);
        logic [TW-1:0] t;
        logic [TW-1:0] term;
        t = '0;
        for (int m = 0; m < ND; m++) begin
            term = '0;
            term[20:0] = {2'b00, c[m]} + {2'b00, s[m]};
            t = t + (term << (16 * m));
        end
        return t;
    endfunction

    task automatic rand_operand();
        for (int m = 0; m < ND; m++) begin
            c_in[m] = 19'($urandom);
            s_in[m] = 19'($urandom);
        end
    endtask

    task automatic start_op(input bit hold_valid);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (in_ready !== 1'b1 && b < 100);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_ready: in_ready=%b after %0d cycles, want 1", in_ready, b);
        end
        in_valid = 1'b1;
        @(negedge clk);
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic collect(input bit rand_ready);
        logic [15:0] prev_digit;
        logic [7:0]  prev_idx;
        logic        prev_last;
        bit          prev_stall;
        bit          done;
        int          budget;
        for (int i = 0; i < ND; i++) begin
            got_digit[i] = 'x;
            got_index[i] = 'x;
            got_last[i]  = 1'bx;
            got_cyc[i]   = -1;
        end
        n_got = 0; timeout = 1'b0; hold_err = 0; got_carry = 'x;
        prev_stall = 1'b0; done = 1'b0; budget = 0;
        prev_digit = '0; prev_idx = '0; prev_last = 1'b0;
        while (!done && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (prev_stall && (out_valid !== 1'b1 || out_digit !== prev_digit ||
                               out_index !== prev_idx || out_last !== prev_last)) hold_err++;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    if (n_got < ND) begin
                        got_digit[n_got] = out_digit;
                        got_index[n_got] = out_index;
                        got_last[n_got]  = out_last;
                        got_cyc[n_got]   = budget;
                    end
                    n_got++;
                    if (out_last === 1'b1) begin
                        done = 1'b1;
                        got_carry = carry_out;
                    end
                end
                prev_stall = !out_ready;
                prev_digit = out_digit;
                prev_idx   = out_index;
                prev_last  = out_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
        if (!done) timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        rand_operand();
        @(negedge clk);
        @(negedge clk);
        vectors += 6;
        if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_last !== 1'b0)   begin miscompares++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        if (out_digit !== 16'h0) begin miscompares++; $display("FAIL rst_out_digit: got %h want 0", out_digit); end
        if (out_index !== 8'h0)  begin miscompares++; $display("FAIL rst_out_index: got %h want 0", out_index); end
        if (carry_out !== 5'h0)  begin miscompares++; $display("FAIL rst_carry_out: got %h want 0", carry_out); end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_zero();
        c_in = '0; s_in = '0;
        start_op(1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_early_valid: got %b want 0", out_valid); end
        collect(1'b0);
        vectors += 4;
        if (timeout || n_got != ND) begin miscompares++; $display("FAIL zero_count: got %0d timeout=%0b want %0d", n_got, timeout, ND); end
        if (got_cyc[0] != 1) begin miscompares++; $display("FAIL zero_latency: got %0d want 1", got_cyc[0]); end
        if (got_cyc[ND-1] - got_cyc[0] != ND - 1) begin miscompares++; $display("FAIL zero_throughput: got %0d want %0d", got_cyc[ND-1] - got_cyc[0], ND - 1); end
        if (got_carry !== 5'h0) begin miscompares++; $display("FAIL zero_carry_out: got %h want 0", got_carry); end
        for (int m = 0; m < ND; m++) begin
            vectors++;
            if (got_digit[m] !== 16'h0000 || got_index[m] !== 8'(m) || got_last[m] !== (m == ND - 1)) begin
                miscompares++;
                $display("FAIL zero_digit[%0d]: got %h idx %0d last %b want 0000 idx %0d last %b",
                         m, got_digit[m], got_index[m], got_last[m], m, (m == ND - 1));
            end
        end
    endtask

    task automatic test_carry_chain();
        for (int m = 0; m < ND; m++) begin
            c_in[m] = 19'h0FFFF;
            s_in[m] = 19'h00001;
        end
        exp_total = golden(c_in, s_in);
        start_op(1'b0);
        collect(1'b0);
        vectors += 4;
        if (got_digit[0] !== 16'h0000)    begin miscompares++; $display("FAIL chain_d0: got %h want 0000", got_digit[0]); end
        if (got_digit[1] !== 16'h0001)    begin miscompares++; $display("FAIL chain_d1: got %h want 0001", got_digit[1]); end
        if (got_digit[ND-1] !== 16'h0001) begin miscompares++; $display("FAIL chain_dlast: got %h want 0001", got_digit[ND-1]); end
        if (got_carry !== 5'h01)          begin miscompares++; $display("FAIL chain_carry_out: got %h want 01", got_carry); end
        for (int m = 0; m < ND; m++) begin
            vectors++;
            if (got_digit[m] !== exp_total[16*m +: 16]) begin
                miscompares++;
                $display("FAIL chain_gold[%0d]: got %h want %h", m, got_digit[m], exp_total[16*m +: 16]);
            end
        end
    endtask

    task automatic test_saturated();
        for (int m = 0; m < ND; m++) begin
            c_in[m] = 19'h7FFFF;
            s_in[m] = 19'h7FFFF;
        end
        exp_total = golden(c_in, s_in);
        start_op(1'b0);
        collect(1'b0);
        vectors += 5;
        if (got_digit[0] !== 16'hFFFE) begin miscompares++; $display("FAIL sat_d0: got %h want FFFE", got_digit[0]); end
        if (got_digit[1] !== 16'h000D) begin miscompares++; $display("FAIL sat_d1: got %h want 000D", got_digit[1]); end
        if (got_digit[2] !== 16'h000E) begin miscompares++; $display("FAIL sat_d2: got %h want 000E", got_digit[2]); end
        if (got_carry !== 5'h10)       begin miscompares++; $display("FAIL sat_carry_out: got %h want 10", got_carry); end
        if ({11'd0, got_carry} !== exp_total[TW-1 -: 16]) begin
            miscompares++; $display("FAIL sat_carry_gold: got %h want %h", got_carry, exp_total[TW-1 -: 16]);
        end
        for (int m = 0; m < ND; m++) begin
            vectors++;
            if (got_digit[m] !== exp_total[16*m +: 16]) begin
                miscompares++;
                $display("FAIL sat_gold[%0d]: got %h want %h", m, got_digit[m], exp_total[16*m +: 16]);
            end
        end
    endtask

    task automatic test_random_stall();
        rand_operand();
        exp_total = golden(c_in, s_in);
        start_op(1'b0);
        collect(1'b0);
        vectors++;
        if ({11'd0, got_carry} !== exp_total[TW-1 -: 16]) begin
            miscompares++; $display("FAIL rnd_carry_gold: got %h want %h", got_carry, exp_total[TW-1 -: 16]);
        end
        for (int m = 0; m < ND; m++) begin
            ref_digit[m] = got_digit[m];
            vectors++;
            if (got_digit[m] !== exp_total[16*m +: 16]) begin
                miscompares++;
                $display("FAIL rnd_gold[%0d]: got %h want %h", m, got_digit[m], exp_total[16*m +: 16]);
            end
        end
        start_op(1'b0);
        collect(1'b1);
        out_ready = 1'b1;
        vectors += 3;
        if (timeout || n_got != ND) begin miscompares++; $display("FAIL stall_count: got %0d timeout=%0b want %0d", n_got, timeout, ND); end
        if (hold_err != 0) begin miscompares++; $display("FAIL stall_hold: got %0d unstable stall cycles want 0", hold_err); end
        if ({11'd0, got_carry} !== exp_total[TW-1 -: 16]) begin
            miscompares++; $display("FAIL stall_carry: got %h want %h", got_carry, exp_total[TW-1 -: 16]);
        end
        for (int m = 0; m < ND; m++) begin
            vectors++;
            if (got_digit[m] !== ref_digit[m] || got_index[m] !== 8'(m)) begin
                miscompares++;
                $display("FAIL stall_digit[%0d]: got %h idx %0d want %h idx %0d", m, got_digit[m], got_index[m], ref_digit[m], m);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        rand_operand();
        start_op(1'b0);
        out_ready = 1'b1;
        b = 0;
        while (!(out_valid === 1'b1 && out_index === 8'd50) && b < 500) begin
            @(negedge clk);
            b++;
        end
        vectors++;
        if (b >= 500) begin miscompares++; $display("FAIL mid_reach50: index 50 not seen, last idx %0d", out_index); end
        reset = 1'b1;
        @(negedge clk);
        vectors += 3;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        if (out_index !== 8'h0) begin miscompares++; $display("FAIL mid_out_index: got %0d want 0", out_index); end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_resume: got %b want 0", out_valid); end
        rand_operand();
        exp_total = golden(c_in, s_in);
        start_op(1'b0);
        collect(1'b0);
        vectors += 2;
        if (timeout || n_got != ND) begin miscompares++; $display("FAIL mid_new_count: got %0d want %0d", n_got, ND); end
        if (got_index[0] !== 8'h0 || got_digit[0] !== exp_total[15:0]) begin
            miscompares++; $display("FAIL mid_new_d0: got %h idx %0d want %h idx 0", got_digit[0], got_index[0], exp_total[15:0]);
        end
        for (int m = 0; m < ND; m++) begin
            vectors++;
            if (got_digit[m] !== exp_total[16*m +: 16]) begin
                miscompares++;
                $display("FAIL mid_gold[%0d]: got %h want %h", m, got_digit[m], exp_total[16*m +: 16]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [ND-1:0][RW-1:0] c_b;
        logic [ND-1:0][RW-1:0] s_b;
        logic [TW-1:0]         exp_b;
        rand_operand();
        c_b = c_in; s_b = s_in;
        exp_b = golden(c_b, s_b);
        rand_operand();
        exp_total = golden(c_in, s_in);
        start_op(1'b1);
        c_in = c_b; s_in = s_b;
        collect(1'b0);
        vectors++;
        if (timeout || n_got != ND) begin miscompares++; $display("FAIL b2b_a_count: got %0d want %0d", n_got, ND); end
        for (int m = 0; m < ND; m++) begin
            vectors++;
            if (got_digit[m] !== exp_total[16*m +: 16]) begin
                miscompares++;
                $display("FAIL b2b_a_gold[%0d]: got %h want %h", m, got_digit[m], exp_total[16*m +: 16]);
            end
        end
        @(negedge clk);
        vectors += 2;
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL b2b_idle_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_valid: got %b want 0", out_valid); end
        @(negedge clk);
        vectors += 2;
        if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL b2b_capture_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_capture_valid: got %b want 0", out_valid); end
        in_valid = 1'b0;
        collect(1'b0);
        vectors += 3;
        if (timeout || n_got != ND) begin miscompares++; $display("FAIL b2b_b_count: got %0d want %0d", n_got, ND); end
        if (got_cyc[0] != 1) begin miscompares++; $display("FAIL b2b_b_latency: got %0d want 1", got_cyc[0]); end
        if ({11'd0, got_carry} !== exp_b[TW-1 -: 16]) begin
            miscompares++; $display("FAIL b2b_b_carry: got %h want %h", got_carry, exp_b[TW-1 -: 16]);
        end
        for (int m = 0; m < ND; m++) begin
            vectors++;
            if (got_digit[m] !== exp_b[16*m +: 16]) begin
                miscompares++;
                $display("FAIL b2b_b_gold[%0d]: got %h want %h", m, got_digit[m], exp_b[16*m +: 16]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        c_in = '0; s_in = '0;
        test_reset();
        test_zero();
        test_carry_chain();
        test_saturated();
        test_random_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
